// File: rtl/add_unit_pkg.sv
// Constants shared by the registered adder and its combinational core.
package add_unit_pkg;

  localparam logic SAT_WRAP = 1'b0;
  localparam logic SAT_SAT  = 1'b1;

endpackage

// File: rtl/add_unit_core.sv
// Combinational add_core: raw (DATAWIDTH+1)-bit sum with carry, signed overflow
// and optional unsigned saturation.
module add_core
  import add_unit_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sat,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 carry,
  output logic                 ovf
);

  localparam int MSB = DATAWIDTH - 1;

  logic [DATAWIDTH:0] raw;

  assign raw   = {1'b0, a} + {1'b0, b};
  assign carry = raw[DATAWIDTH];

  // Overflow always comes from the raw sum, so it is reported even when saturating.
  assign ovf = (a[MSB] == b[MSB]) && (raw[MSB] != a[MSB]);

  always_comb begin
    sum = raw[MSB:0];
    if ((sat == SAT_SAT) && carry) begin
      sum = '1;
    end
  end

endmodule

// File: rtl/add_unit.sv
// Registered adder with a single-entry valid/ready output register; accepted
// operands appear on the outputs one cycle later.
module add_unit
  import add_unit_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 carry,
  output logic                 ovf
);

  logic [DATAWIDTH-1:0] core_sum;
  logic                 core_carry;
  logic                 core_ovf;

  logic                 valid_q, valid_d;
  logic [DATAWIDTH-1:0] sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 accept;
  logic                 consume;

  add_core #(
    .DATAWIDTH(DATAWIDTH)
  ) u_core (
    .a    (a),
    .b    (b),
    .sat  (sat),
    .sum  (core_sum),
    .carry(core_carry),
    .ovf  (core_ovf)
  );

  // No skid buffer: a slot frees up in the same cycle the consumer takes the result.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (accept) begin
      valid_d = 1'b1;
      sum_d   = core_sum;
      carry_d = core_carry;
      ovf_d   = core_ovf;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_unit.sv
// Scoreboard bench for add_unit: accepted operands push an arithmetic model
// result; a monitor pops and compares on every consumed output.
module tb_add_unit;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry;
  logic         ovf;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  add_unit #(.DATAWIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sat      (sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry    (carry),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(longint unsigned av, longint unsigned bv, bit s);
    exp_t            e;
    longint unsigned full;
    longint          sa, sb, ss;
    longint          lim;
    full = av + bv;
    lim  = longint'(1) << W;
    e.c  = (full >= lim);
    e.s  = (s && e.c) ? W'(lim - 1) : W'(full % lim);
    sa   = (av >= lim / 2) ? longint'(av) - lim : longint'(av);
    sb   = (bv >= lim / 2) ? longint'(bv) - lim : longint'(bv);
    ss   = sa + sb;
    e.o  = (ss > lim / 2 - 1) || (ss < -(lim / 2));
    return e;
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands and waits for the accept; waited returns the stall cycles.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                      output int waited);
    bit done;
    in_valid = 1'b1;
    a = av;
    b = bv;
    sat = s;
    done = 0;
    waited = 0;
    while (!done && waited < 20) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(av, bv, s));
        done = 1;
      end else begin
        waited++;
      end
      step();
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic sendchk(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input bit no_stall);
    int waited;
    send(av, bv, s, waited);
    if (no_stall) chk("no_bubble", waited, 0);
    chk("latency_valid", out_valid, 1);
    chk("dir_sum", sum, es);
    chk("dir_carry", carry, ec);
    chk("dir_ovf", ovf, eo);
  endtask

  // Monitor: every cycle in which the consumer takes a result is checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sum", sum, e.s);
          chk("sb_carry", carry, e.c);
          chk("sb_ovf", ovf, e.o);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    step();

    out_ready = 1'b1;
    sendchk(8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1);
    sendchk(8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1);
    sendchk(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    sendchk(8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1, 1'b1);
    sendchk(8'd200, 8'd100, 1'b1, 8'd255, 1'b1, 1'b0, 1'b1);
    sendchk(8'd100, 8'd100, 1'b1, 8'd200, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("hold_sum", sum, 200);

    sendchk(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    a = 8'd9;
    b = 8'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, 7);
      step();
    end
    out_ready = 1'b1;
    sendchk(8'd9, 8'd9, 1'b0, 8'd18, 1'b0, 1'b0, 1'b1);

    sendchk(8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    sendchk(8'd1, 8'd2, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
    sendchk(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0, 1'b1);
    sendchk(8'd255, 8'd255, 1'b0, 8'd254, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();

    sendchk(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    sendchk(8'd5, 8'd6, 1'b0, 8'd11, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      a   = W'($urandom);
      b   = W'($urandom);
      sat = $urandom_range(0, 1) == 1;
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sat));
      step();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      step();
      waited++;
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_unit.md
Name: add_unit

Overview:
- Registered two-operand unsigned adder for the datapath: sum = a + b, truncated to DATAWIDTH bits, with carry-out and signed-overflow flags.
- Optional saturating mode.
- Single-entry output register with valid/ready handshake; one-cycle latency.
- Sits between operand producers and any downstream consumer that may apply backpressure.

Parameters:
- DATAWIDTH, 8, width of a, b and sum in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b and sat are presented this cycle.
- in_ready  output  1  unit can accept operands this cycle.
- a  input  DATAWIDTH  operand A, unsigned.
- b  input  DATAWIDTH  operand B, unsigned.
- sat  input  1  0 = wrap mode, 1 = unsigned saturate mode; sampled with the operands.
- out_valid  output  1  sum, carry and ovf hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  DATAWIDTH  result.
- carry  output  1  unsigned carry-out of the raw addition.
- ovf  output  1  two's-complement overflow of the raw addition.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, sum=0, carry=0, ovf=0; in_ready=1 as soon as rst_n is high.
- Raw addition is DATAWIDTH+1 bits wide: raw = {0,a} + {0,b}; carry = raw[DATAWIDTH].
- Wrap mode: sum = raw[DATAWIDTH-1:0], i.e. modulo 2^DATAWIDTH.
- Saturate mode: sum = all-ones when carry=1, otherwise raw[DATAWIDTH-1:0].
- ovf = (a[MSB]==b[MSB]) && (raw[MSB]!=a[MSB]). Computed from the raw sum in both modes; independent of sat.
- carry and ovf are reported in both modes.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Result is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational pass-through of out_ready; no skid buffer).
  - On accept: sum, carry and ovf register the new result and out_valid=1 at the next rising edge. Latency is exactly 1 cycle.
  - Consume without accept in the same cycle: out_valid goes to 0 next edge; sum, carry and ovf hold their last values.
  - Simultaneous consume and accept: the new result replaces the old one, out_valid stays 1, full throughput of 1 result per cycle.
  - Backpressure (out_valid=1, out_ready=0): outputs stay stable, in_ready=0, and input data is ignored.
- a, b and sat are don't-care when in_valid=0. No X propagation into the registers when in_valid=0.
- Reset asserted mid-transfer discards the held result immediately.
- No internal state beyond the output register.

Decomposition:
- Shared package: localparams SAT_WRAP=1'b0 and SAT_SAT=1'b1.
- One combinational sub-module, add_core: inputs a, b, sat; outputs sum, carry, ovf. It is parameterised by DATAWIDTH and contains no clock.
- add_unit wraps add_core with the output register and handshake logic.

Test Plan:
- Basic add: wrap mode, a=1, b=0, then a=1, b=1, out_ready=1 -> sum=1 then sum=2, carry=0, ovf=0; each result arrives 1 cycle after its accept.
- Wrap boundary: a=255, b=1, sat=0 -> sum=0, carry=1, ovf=0. Also a=127, b=1 -> sum=128, carry=0, ovf=1.
- Saturate: a=200, b=100, sat=1 -> sum=255, carry=1. Also a=100, b=100, sat=1 -> sum=200, carry=0, ovf=1.
- Backpressure: accept a=3, b=4, then hold out_ready=0 for 3 cycles while driving new operands -> sum stays 7, out_valid=1, in_ready=0. Release out_ready -> 7 is consumed and the pending input is accepted in the same cycle.
- Back-to-back: in_valid=1 and out_ready=1 for 4 cycles with pairs (0,0), (1,2), (10,20), (255,255) -> sums 0, 3, 30, 254 (last one carry=1) on consecutive cycles, no bubbles.
- Reset mid-operation: with out_valid=1 and sum=7, pulse rst_n low between clock edges -> out_valid=0 and sum=0 immediately; normal operation resumes after release.
